serial_word_deserializer: RTL
=============================

// Module: serial_word_deserializer
// PURPOSE
//  Downstream stage of the parameterized shift register: consumes its serial 'shiftout' stream.
//  Frames are UART-like: start bit 0, then WIDTH data bits, then stop bit 1. Idle line is 1.
//  Reassembles each frame into a parallel word and presents it on a one-word valid/ready buffer.
//  Flags bad stop bits (frame_err) and words lost while the buffer was full (overrun).
// PARAMETERS
//  WIDTH            8       data bits per frame; must be >= 2
//  SHIFT_DIRECTION  "LEFT"  "LEFT": first data bit is the MSB (matches a left-shifting source); "RIGHT": first is the LSB
// PORTS
//  clock      in   1      rising-edge clock
//  aclr       in   1      asynchronous clear, active-high
//  sclr       in   1      synchronous clear, active-high; priority over all other inputs
//  enable     in   1      bit strobe; serial_in is sampled only on edges where enable=1
//  serial_in  in   1      serial data (upstream shiftout)
//  q          out  WIDTH  received word (registered)
//  q_valid    out  1      q holds an unconsumed word
//  q_ready    in   1      consumer accepts q this cycle when q_valid=1
//  frame_err  out  1      one-cycle pulse: stop bit sampled as 0
//  overrun    out  1      sticky: a good frame was dropped because the buffer was full
//  busy       out  1      state != IDLE (combinational decode of state register)
// BEHAVIOUR
//  Reset (aclr async, or sclr sync): state=IDLE, shreg=0, bit_cnt=0, q=0, q_valid=0, frame_err=0, overrun=0.
//  FSM, advanced only on edges with enable=1 (enable=0 holds state, shreg and bit_cnt):
//   IDLE:      serial_in=0 -> DATA with bit_cnt=0. serial_in=1 -> stay.
//   DATA:      shift serial_in into shreg; bit_cnt++. After the WIDTH-th bit -> STOP.
//              LEFT:  shreg <= {shreg[WIDTH-2:0], serial_in}
//              RIGHT: shreg <= {serial_in, shreg[WIDTH-1:1]}
//   STOP:      serial_in=1 -> deliver shreg (see below) and go to IDLE.
//              serial_in=0 -> frame_err=1 for the next cycle; word discarded; go to WAIT_IDLE.
//   WAIT_IDLE: stay until an enabled sample with serial_in=1 -> IDLE. A low line here never starts a frame.
//  Output handshake (evaluated every clock, independent of enable):
//   - Transfer occurs when q_valid && q_ready; q_valid clears next cycle unless a delivery happens in the same cycle.
//   - Delivery when q_valid=0, or q_valid=1 && q_ready=1 in the same cycle: q<=shreg, q_valid<=1.
//   - Delivery when q_valid=1 && q_ready=0: word dropped; q unchanged; overrun<=1, held until aclr/sclr.
//  Latency: q/q_valid update on the clock edge after the edge that samples a good stop bit.
//  frame_err and overrun are registered outputs. frame_err never asserts outside a STOP sample.
//  Reset mid-frame: the partial word is lost, no flag is raised, and the next frame decodes normally.
//  bit_cnt width: $clog2(WIDTH+1). The counter never wraps because it is reset on entry to DATA.
// STRUCTURE
//  State encoding in shared package shift_pkg: ST_IDLE=2'd0, ST_DATA=2'd1, ST_STOP=2'd2, ST_WAIT_IDLE=2'd3.
//  Direction strings "LEFT"/"RIGHT" are also defined in shift_pkg, shared with the shift register.
//  One sub-module, word_out_buffer (q/q_valid/q_ready/overrun logic). The FSM and shift register stay in the top level.
// TESTING  (WIDTH=8 unless noted; drive stimulus on negedge; enable=1 unless noted)
//  1. aclr=1 mid-DATA, with clock stopped -> all outputs 0 immediately; busy=0.
//  2. LEFT: serial 0,1,0,0,1,1,1,0,0,1 -> q=8'h9C, q_valid=1 one edge after stop; q_ready=1 -> q_valid=0 next edge.
//  3. RIGHT: the same sequence -> q=8'h39.
//  4. Stop bit 0 -> frame_err one-cycle pulse; q_valid stays 0; following 0 bits are ignored until a 1, then frame 8'hA5 decodes.
//  5. q_ready=0; send 8'h11 then 8'h22 -> q stays 8'h11, overrun=1 (sticky); sclr=1 -> overrun=0, q_valid=0.
//  6. enable toggled randomly during frame 8'h5A -> result unchanged. q_ready=1 during a delivery cycle -> back-to-back words, no overrun.

Source files
------------

// File: rtl/shift_pkg.sv
// Definitions shared by the shift register and its downstream deserializer:
// the receive FSM state encoding and the shift-direction names.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DATA      = 2'd1,
        ST_STOP      = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } rx_state_t;

    localparam string DIR_LEFT  = "LEFT";
    localparam string DIR_RIGHT = "RIGHT";

endpackage

// File: rtl/word_out_buffer.sv
// One-word valid/ready holding buffer for received words; a delivery into a
// full, unacknowledged buffer is dropped and latches the sticky overrun flag.
module word_out_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             sclr,
    input  logic             deliver,
    input  logic [WIDTH-1:0] word_in,
    input  logic             q_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && q_ready) begin
            valid_d = 1'b0;
        end
        // A word being consumed this cycle frees the slot for a same-cycle delivery.
        if (deliver) begin
            if (!valid_q || q_ready) begin
                word_d  = word_in;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (sclr) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign q       = word_q;
    assign q_valid = valid_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// Receives UART-like frames (start 0, WIDTH data bits, stop 1) from an
// upstream shift register's serial output and hands each word to a one-word buffer.
module serial_word_deserializer
    import shift_pkg::*;
#(
    parameter int    WIDTH           = 8,
    parameter string SHIFT_DIRECTION = DIR_LEFT
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             sclr,
    input  logic             enable,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W       = $clog2(WIDTH + 1);
    localparam bit SHIFT_RIGHT = (SHIFT_DIRECTION == DIR_RIGHT);

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             frame_err_q, frame_err_d;
    logic             deliver_q, deliver_d;
    logic [WIDTH-1:0] shreg_shifted;

    generate
        if (SHIFT_RIGHT) begin : g_shift_right
            assign shreg_shifted = {serial_in, shreg_q[WIDTH-1:1]};
        end else begin : g_shift_left
            assign shreg_shifted = {shreg_q[WIDTH-2:0], serial_in};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        frame_err_d = 1'b0;
        deliver_d   = 1'b0;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (!serial_in) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d   = shreg_shifted;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    // shreg is frozen outside DATA, so it is still intact when
                    // the buffer consumes it on the following edge.
                    if (serial_in) begin
                        deliver_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (serial_in) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            deliver_q   <= 1'b0;
        end else if (sclr) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            deliver_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_err_q <= frame_err_d;
            deliver_q   <= deliver_d;
        end
    end

    word_out_buffer #(
        .WIDTH(WIDTH)
    ) u_word_out_buffer (
        .clock   (clock),
        .aclr    (aclr),
        .sclr    (sclr),
        .deliver (deliver_q),
        .word_in (shreg_q),
        .q_ready (q_ready),
        .q       (q),
        .q_valid (q_valid),
        .overrun (overrun)
    );

    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
